// File: rtl/dcache_pkg.sv
// Shared dcache constants and types for the MSHR memory-request arbiter.
package dcache_pkg;

  localparam int MSHR_NUM     = 4;
  localparam int MSHR_NUM_LOG = 2;
  localparam int PADDR_W      = 48;
  localparam int MAX_OUT      = 3;
  localparam int LINE_W       = 512;

  // One memory request as it sits in the outgoing slot.
  typedef struct packed {
    logic [PADDR_W-1:0]      paddr;
    logic [MSHR_NUM_LOG-1:0] mshrid;
  } mem_req_t;

endpackage

// File: rtl/dcache_mshr_mem_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping around. Purely combinational so it can be reused by the refill path.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int LOG = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [LOG-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [LOG-1:0] id_o,
  output logic           valid_o
);

  logic [LOG-1:0] idx;

  // Scan from the pointer upward; N is a power of two so the index wraps naturally.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_i + LOG'(k);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
    grant_o = valid_o ? (N'(1) << id_o) : '0;
  end

endmodule

// File: rtl/dcache_mshr_mem_arb.sv
// Shares the single L2/memory request channel among the dcache MSHR entries.
// Round-robin grant into a registered request slot, credit-limited outstanding
// misses, in-flight id tracking, and one-hot routing of refill responses.
// Optional macro MSHR_MEM_ARB_PERF_EN adds saturating performance counters.
module dcache_mshr_mem_arb #(
  parameter int MSHR_NUM     = dcache_pkg::MSHR_NUM,
  parameter int MSHR_NUM_LOG = dcache_pkg::MSHR_NUM_LOG,
  parameter int PADDR_W      = dcache_pkg::PADDR_W,
  parameter int MAX_OUT      = dcache_pkg::MAX_OUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [MSHR_NUM-1:0]           req_valid_vec,
  input  logic [MSHR_NUM*PADDR_W-1:0]   req_paddr_vec,
  output logic [MSHR_NUM-1:0]           req_ready_vec,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [PADDR_W-1:0]            mem_req_paddr,
  output logic [MSHR_NUM_LOG-1:0]       mem_req_mshrid,
  input  logic                          mem_resp_valid,
  input  logic [MSHR_NUM_LOG-1:0]       mem_resp_mshrid,
  input  logic [dcache_pkg::LINE_W-1:0] mem_resp_data,
  output logic [MSHR_NUM-1:0]           resp_valid_vec,
  output logic [dcache_pkg::LINE_W-1:0] resp_data,
  output logic [MSHR_NUM_LOG:0]         outstanding_cnt,
  output logic                          resp_err
`ifdef MSHR_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_stall_credit_cnt,
  output logic [31:0]                   perf_stall_ready_cnt
`endif
);

  import dcache_pkg::*;

  localparam int CNT_W = MSHR_NUM_LOG + 1;

  typedef struct packed {
    logic [PADDR_W-1:0]      paddr;
    logic [MSHR_NUM_LOG-1:0] mshrid;
  } slot_t;

  logic [MSHR_NUM-1:0]     inflight_q, inflight_d;
  logic [MSHR_NUM_LOG-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    slot_valid_q;
  slot_t                   slot_q;
  logic [MSHR_NUM-1:0]     resp_valid_q;
  logic [LINE_W-1:0]       resp_data_q;
  logic                    resp_err_q;

  logic [MSHR_NUM-1:0]     eligible;
  logic [MSHR_NUM-1:0]     grant;
  logic [MSHR_NUM_LOG-1:0] win_id;
  logic                    win_any;
  logic [PADDR_W-1:0]      win_paddr;
  logic                    load;
  logic                    resp_hit;
  logic [MSHR_NUM-1:0]     resp_onehot;

  rr_arbiter #(
    .N   (MSHR_NUM),
    .LOG (MSHR_NUM_LOG)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .id_o    (win_id),
    .valid_o (win_any)
  );

  // Grant decision and next-state for the in-flight bitmap, credits and pointer.
  // Credits compare against the registered count, so a response arriving while
  // saturated only frees a slot from the following cycle.
  always_comb begin
    eligible      = req_valid_vec & ~inflight_q;
    load          = ~reset & (~slot_valid_q | mem_req_ready)
                  & (cnt_q < CNT_W'(MAX_OUT)) & win_any;
    req_ready_vec = load ? grant : '0;
    resp_onehot   = MSHR_NUM'(1) << mem_resp_mshrid;
    resp_hit      = mem_resp_valid & inflight_q[mem_resp_mshrid];
    inflight_d    = (inflight_q | req_ready_vec) & ~(resp_hit ? resp_onehot : '0);
    cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, load} - {{(CNT_W-1){1'b0}}, resp_hit};
    rr_ptr_d      = load ? (win_id + MSHR_NUM_LOG'(1)) : rr_ptr_q;
  end

  // Select the winning entry's address out of the flattened request bus.
  always_comb begin
    win_paddr = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (win_id == MSHR_NUM_LOG'(i)) win_paddr = req_paddr_vec[i*PADDR_W +: PADDR_W];
    end
  end

  // Arbitration state: in-flight ids, credit count and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Outgoing request slot: loads on grant, empties on handshake with no new load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
    end else if (load) begin
      slot_valid_q <= 1'b1;
      slot_q       <= '{paddr: win_paddr, mshrid: win_id};
    end else if (mem_req_ready) begin
      slot_valid_q <= 1'b0;
    end
  end

  // Response routing: one-cycle one-hot pulse, held line data, sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_hit ? resp_onehot : '0;
      if (resp_hit) resp_data_q <= mem_resp_data;
      if (mem_resp_valid && !resp_hit) resp_err_q <= 1'b1;
    end
  end

  assign mem_req_valid   = slot_valid_q;
  assign mem_req_paddr   = slot_q.paddr;
  assign mem_req_mshrid  = slot_q.mshrid;
  assign resp_valid_vec  = resp_valid_q;
  assign resp_data       = resp_data_q;
  assign outstanding_cnt = cnt_q;
  assign resp_err        = resp_err_q;

`ifdef MSHR_MEM_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_credit_q, perf_stall_ready_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counters: handshakes, credit stalls, downstream stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issue_q        <= '0;
      perf_stall_credit_q <= '0;
      perf_stall_ready_q  <= '0;
    end else begin
      perf_issue_q        <= sat_inc(perf_issue_q, slot_valid_q & mem_req_ready);
      perf_stall_credit_q <= sat_inc(perf_stall_credit_q,
                                     (|eligible) & (cnt_q == CNT_W'(MAX_OUT)));
      perf_stall_ready_q  <= sat_inc(perf_stall_ready_q, slot_valid_q & ~mem_req_ready);
    end
  end

  assign perf_issue_cnt        = perf_issue_q;
  assign perf_stall_credit_cnt = perf_stall_credit_q;
  assign perf_stall_ready_cnt  = perf_stall_ready_q;
`endif

endmodule

// File: tb/tb_dcache_mshr_mem_arb.sv
// Bench for dcache_mshr_mem_arb: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_dcache_mshr_mem_arb;

  localparam int N       = 4;
  localparam int AW      = 48;
  localparam int MAX_OUT = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid_vec = '0;
  logic [N*AW-1:0] req_paddr_vec = '0;
  logic [N-1:0]   req_ready_vec;
  logic           mem_req_valid;
  logic           mem_req_ready = 1'b0;
  logic [AW-1:0]  mem_req_paddr;
  logic [1:0]     mem_req_mshrid;
  logic           mem_resp_valid = 1'b0;
  logic [1:0]     mem_resp_mshrid = '0;
  logic [511:0]   mem_resp_data = '0;
  logic [N-1:0]   resp_valid_vec;
  logic [511:0]   resp_data;
  logic [2:0]     outstanding_cnt;
  logic           resp_err;
`ifdef MSHR_MEM_ARB_PERF_EN
  logic [31:0]    perf_issue_cnt, perf_stall_credit_cnt, perf_stall_ready_cnt;
`endif

  dcache_mshr_mem_arb dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid_vec   (req_valid_vec),
    .req_paddr_vec   (req_paddr_vec),
    .req_ready_vec   (req_ready_vec),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_paddr   (mem_req_paddr),
    .mem_req_mshrid  (mem_req_mshrid),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_mshrid (mem_resp_mshrid),
    .mem_resp_data   (mem_resp_data),
    .resp_valid_vec  (resp_valid_vec),
    .resp_data       (resp_data),
    .outstanding_cnt (outstanding_cnt),
    .resp_err        (resp_err)
`ifdef MSHR_MEM_ARB_PERF_EN
    ,
    .perf_issue_cnt        (perf_issue_cnt),
    .perf_stall_credit_cnt (perf_stall_credit_cnt),
    .perf_stall_ready_cnt  (perf_stall_ready_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  logic [N-1:0] granted_mask = '0;
  int grant_total = 0;

  // Behavioural model state
  bit           m_infl [N];
  int           m_cnt, m_ptr;
  bit           m_sv;
  logic [AW-1:0] m_pa;
  logic [1:0]   m_id;
  logic [N-1:0] m_rv;
  logic [511:0] m_rd;
  bit           m_err;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_infl[i] = 1'b0;
    m_cnt = 0; m_ptr = 0; m_sv = 1'b0; m_pa = '0; m_id = '0;
    m_rv = '0; m_rd = '0; m_err = 1'b0;
  endtask

  // Compare process: checks the DUT against the model mid-cycle, then advances the model.
  always @(negedge clock) begin
    bit any, ld, hit;
    int w;
    logic [N-1:0] exp_rr;
    if (reset) begin
      chk("rst_req_ready", 512'(req_ready_vec), 512'(0));
      chk("rst_mem_req_valid", 512'(mem_req_valid), 512'(0));
      chk("rst_cnt", 512'(outstanding_cnt), 512'(0));
      chk("rst_resp_valid", 512'(resp_valid_vec), 512'(0));
      chk("rst_resp_err", 512'(resp_err), 512'(0));
      model_clear();
    end else begin
      any = 1'b0; w = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!any && req_valid_vec[j] && !m_infl[j]) begin any = 1'b1; w = j; end
      end
      ld = (!m_sv || mem_req_ready) && (m_cnt < MAX_OUT) && any;
      exp_rr = ld ? N'(1 << w) : '0;
      chk("req_ready_vec", 512'(req_ready_vec), 512'(exp_rr));
      chk("mem_req_valid", 512'(mem_req_valid), 512'(m_sv));
      if (m_sv) begin
        chk("mem_req_paddr", 512'(mem_req_paddr), 512'(m_pa));
        chk("mem_req_mshrid", 512'(mem_req_mshrid), 512'(m_id));
      end
      chk("resp_valid_vec", 512'(resp_valid_vec), 512'(m_rv));
      chk("resp_data", resp_data, m_rd);
      chk("outstanding_cnt", 512'(outstanding_cnt), 512'(m_cnt));
      chk("resp_err", 512'(resp_err), 512'(m_err));
      granted_mask = granted_mask | req_ready_vec;
      grant_total += $countones(req_ready_vec);
      // advance model to the next cycle
      hit = mem_resp_valid && m_infl[mem_resp_mshrid];
      if (mem_resp_valid && !hit) m_err = 1'b1;
      m_rv = hit ? N'(1 << mem_resp_mshrid) : '0;
      if (hit) begin
        m_rd = mem_resp_data;
        m_infl[mem_resp_mshrid] = 1'b0;
        m_cnt--;
      end
      if (ld) begin
        m_infl[w] = 1'b1;
        m_cnt++;
        m_ptr = (w + 1) % N;
        m_sv  = 1'b1;
        m_pa  = req_paddr_vec[w*AW +: AW];
        m_id  = 2'(w);
      end else if (mem_req_ready) begin
        m_sv = 1'b0;
      end
    end
  end

  // Advance one clock; entries that saw a grant pulse drop their request.
  task automatic tick();
    @(posedge clock);
    #1;
    req_valid_vec = req_valid_vec & ~granted_mask;
    granted_mask  = '0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid_vec = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    granted_mask = '0;
  endtask

  logic [511:0] a5;
  logic [AW-1:0] pa;
  int r, cid;

  initial begin
    a5 = {64{8'hA5}};
    model_clear();

    // Reset state
    do_reset();
    #1;
    chk("A_req_ready", 512'(req_ready_vec), 512'(0));
    chk("A_valid", 512'(mem_req_valid), 512'(0));
    chk("A_cnt", 512'(outstanding_cnt), 512'(0));
    chk("A_err", 512'(resp_err), 512'(0));

    // Single request from entry 2
    req_valid_vec = 4'b0100;
    req_paddr_vec[2*AW +: AW] = 48'h1000;
    mem_req_ready = 1'b1;
    #1;
    chk("B_grant", 512'(req_ready_vec), 512'(4'b0100));
    tick();
    #1;
    chk("B_valid", 512'(mem_req_valid), 512'(1));
    chk("B_paddr", 512'(mem_req_paddr), 512'(48'h1000));
    chk("B_id", 512'(mem_req_mshrid), 512'(2));
    chk("B_cnt", 512'(outstanding_cnt), 512'(1));

    // Response routing and response to a non-outstanding id
    mem_resp_valid = 1'b1; mem_resp_mshrid = 2'd2; mem_resp_data = a5;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("C_resp_vec", 512'(resp_valid_vec), 512'(4'b0100));
    chk("C_resp_data", resp_data, a5);
    chk("C_cnt", 512'(outstanding_cnt), 512'(0));
    tick();
    #1;
    chk("C_pulse_once", 512'(resp_valid_vec), 512'(0));
    mem_resp_valid = 1'b1; mem_resp_mshrid = 2'd2; mem_resp_data = '1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("C_no_pulse", 512'(resp_valid_vec), 512'(0));
    chk("C_err", 512'(resp_err), 512'(1));
    chk("C_data_held", resp_data, a5);

    // Credit limit
    do_reset();
    for (int i = 0; i < N; i++) req_paddr_vec[i*AW +: AW] = 48'h4000 + AW'(i*64);
    req_valid_vec = 4'b1111;
    mem_req_ready = 1'b1;
    r = grant_total;
    #1;
    chk("D_first", 512'(req_ready_vec), 512'(4'b0001));
    repeat (5) tick();
    #1;
    chk("D_grants", 512'(grant_total - r), 512'(3));
    chk("D_cnt", 512'(outstanding_cnt), 512'(3));
    mem_resp_valid = 1'b1; mem_resp_mshrid = 2'd0; mem_resp_data = a5;
    #1;
    chk("D_still_blocked", 512'(req_ready_vec), 512'(0));
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("D_resp_vec", 512'(resp_valid_vec), 512'(4'b0001));
    chk("D_cnt_dec", 512'(outstanding_cnt), 512'(2));
    chk("D_fourth", 512'(req_ready_vec), 512'(4'b1000));
    tick();
    #1;
    chk("D_slot_id", 512'(mem_req_mshrid), 512'(3));
    chk("D_cnt_full", 512'(outstanding_cnt), 512'(3));

    // Backpressure, then async reset with cnt=2 and slot valid
    do_reset();
    req_valid_vec = 4'b0010;
    req_paddr_vec[1*AW +: AW] = 48'h2040;
    req_paddr_vec[3*AW +: AW] = 48'h3080;
    mem_req_ready = 1'b0;
    tick();
    req_valid_vec[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("E_hold_valid", 512'(mem_req_valid), 512'(1));
      chk("E_hold_paddr", 512'(mem_req_paddr), 512'(48'h2040));
      chk("E_hold_id", 512'(mem_req_mshrid), 512'(1));
      chk("E_no_grant", 512'(req_ready_vec), 512'(0));
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("E_b2b_grant", 512'(req_ready_vec), 512'(4'b1000));
    tick();
    #1;
    chk("E_next_id", 512'(mem_req_mshrid), 512'(3));
    chk("E_cnt2", 512'(outstanding_cnt), 512'(2));
    reset = 1'b1;
    #1;
    chk("F_async_valid", 512'(mem_req_valid), 512'(0));
    chk("F_async_paddr", 512'(mem_req_paddr), 512'(0));
    chk("F_async_cnt", 512'(outstanding_cnt), 512'(0));
    chk("F_async_resp", resp_data, 512'(0));
    req_valid_vec = '0; mem_req_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    granted_mask = '0;

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_vec[i] && $urandom_range(3) == 0) begin
          pa = {16'($urandom), $urandom};
          req_paddr_vec[i*AW +: AW] = pa;
          req_valid_vec[i] = 1'b1;
        end
      end
      mem_req_ready = ($urandom_range(3) != 0);
      r = $urandom_range(19);
      mem_resp_valid = 1'b0;
      if (r < 8) begin
        cid = $urandom_range(N-1);
        for (int k = 0; k < N; k++) begin
          if (m_infl[(cid + k) % N]) begin
            mem_resp_valid = 1'b1;
            mem_resp_mshrid = 2'((cid + k) % N);
            break;
          end
        end
      end else if (r == 8) begin
        mem_resp_valid = 1'b1;
        mem_resp_mshrid = 2'($urandom_range(N-1));
      end
      for (int q = 0; q < 16; q++) mem_resp_data[q*32 +: 32] = $urandom;
      tick();
    end
    mem_resp_valid = 1'b0;
    req_valid_vec = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
